vga_timing_controller: RTL and testbench
========================================

VGA_TIMING_CONTROLLER -- requirements
Module: vga_timing_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and resetN.
REQ-002 Parameter DRAW_LATENCY SHALL default to 1 and SHALL set the clk cycles from pixelX/pixelY to valid RGB_in.
REQ-003 Parameters H_VIS, H_FP, H_SYNC, H_BP SHALL default to 640, 16, 96, 48 (H_TOTAL 800).
REQ-004 Parameters V_VIS, V_FP, V_SYNC, V_BP SHALL default to 480, 10, 2, 33 (V_TOTAL 525).
REQ-005 clk  in  1  pixel clock, one pixel per cycle.
REQ-006 resetN  in  1  asynchronous, active-low reset.
REQ-007 RGB_in  in  8  drawn pixel color as {blue[1:0], red[2:0], green[2:0]}, bits [7:6], [5:3], [2:0].
REQ-008 pixelX  out  11  current horizontal count, 0..H_TOTAL-1.
REQ-009 pixelY  out  11  current vertical count, 0..V_TOTAL-1.
REQ-010 startOfFrame  out  1  one-cycle pulse while pixelX=0 and pixelY=0.
REQ-011 frameCount  out  8  completed-frame counter.
REQ-012 VGA_R, VGA_G, VGA_B  out  8 each  expanded color to the DAC.
REQ-013 VGA_HS, VGA_VS  out  1 each  active-low sync.
REQ-014 VGA_BLANK_N  out  1  low outside the visible area.

Function
REQ-015 pixelX SHALL increment every cycle and wrap from H_TOTAL-1 to 0.
REQ-016 pixelY SHALL increment only on the pixelX wrap cycle and wrap from V_TOTAL-1 to 0 on the same cycle that pixelX wraps.
REQ-017 frameCount SHALL increment, modulo 256, on the cycle both counters wrap to (0,0).
REQ-018 visible SHALL equal (pixelX < H_VIS) and (pixelY < V_VIS).
REQ-019 hs_raw SHALL be 0 for pixelX in H_VIS+H_FP .. H_VIS+H_FP+H_SYNC-1 (default 656..751) and 1 otherwise.
REQ-020 vs_raw SHALL be 0 for pixelY in V_VIS+V_FP .. V_VIS+V_FP+V_SYNC-1 (default 490..491) and 1 otherwise.
REQ-021 visible, hs_raw and vs_raw SHALL pass through a shift pipeline of depth DRAW_LATENCY plus one output register.
REQ-022 VGA_HS, VGA_VS and VGA_BLANK_N for count (x,y) SHALL appear DRAW_LATENCY+1 cycles after pixelX/pixelY present (x,y).
REQ-023 RGB_in SHALL be sampled in the cycle it aligns with the delayed visible flag.
REQ-024 The sampled color SHALL be registered to VGA_R/G/B, aligned with the sync outputs of REQ-022.
REQ-025 Color expansion by bit replication SHALL be: VGA_R = {r,r,r[2:1]}, VGA_G = {g,g,g[2:1]}, VGA_B = {b,b,b,b}.
REQ-026 VGA_R/G/B SHALL be forced to 0 whenever the aligned visible flag is 0, regardless of RGB_in.
REQ-027 startOfFrame SHALL be combinational from the counters and SHALL have no extra delay.
REQ-028 There SHALL be no stall or backpressure; RGB_in is assumed valid every cycle.

Reset
REQ-029 While resetN=0, pixelX=0, pixelY=0, frameCount=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
REQ-030 All pipeline stages SHALL clear to hs=1, vs=1, visible=0, color=0.
REQ-031 Reset asserted mid-line or mid-frame SHALL abort the frame immediately.
REQ-032 The first cycle after resetN deasserts SHALL present pixelX=0, pixelY=0 with startOfFrame=1.
REQ-033 The first VGA_BLANK_N=1 after reset SHALL occur exactly DRAW_LATENCY+1 cycles after release.

Verification
REQ-034 Line timing: release reset, run 800 cycles, DRAW_LATENCY=1 -> VGA_HS low exactly for delayed counts 656..751 (96 cycles), first low at cycle 658; pixelX returns to 0 at cycle 800.
REQ-035 Frame timing: run 420000 cycles -> VGA_VS low for exactly 1600 cycles per frame; frameCount=1 after 420000 cycles; startOfFrame pulses once per 420000 cycles.
REQ-036 Color path: hold RGB_in=8'b10_101_011 -> VGA_B=8'hAA, VGA_R=8'hB6, VGA_G=8'h6D at visible pixels; all three 0 at pixelX-aligned count 640..799.
REQ-037 Alignment: drive RGB_in = pixelX[7:0] delayed by DRAW_LATENCY -> output color at delayed x=5 decodes from 8'h05 (VGA_G=8'hB6, VGA_R=0, VGA_B=0), and VGA_BLANK_N falls on the same cycle as delayed x=640.
REQ-038 Reset mid-frame: assert resetN=0 at pixelY=300, pixelX=400 for 3 cycles -> all outputs at REQ-029 values during reset; pixelX=0, pixelY=0, startOfFrame=1 on the first cycle after release.
REQ-039 Wrap/overflow: preload 255 frames -> frameCount wraps 255->0 on the next (0,0) cycle.

Source files
------------

// File: rtl/vga_timing_controller_if.sv
// ---------------------------------------------------------------------------
// vga_timing_controller_if
// Groups the color input and all timing/DAC outputs of the VGA timing
// controller. Clock and reset stay plain ports on the controller.
//   master : the timing controller (drives counters, sync, blank, color)
//   slave  : the drawing logic / display side (drives RGB_in)
// Signals:
//   RGB_in       8   drawn color {blue[1:0], red[2:0], green[2:0]}
//   pixelX/Y     11  current horizontal / vertical count
//   startOfFrame 1   high while the counters sit at (0,0)
//   frameCount   8   completed-frame counter (wraps mod 256)
//   VGA_R/G/B    8   expanded color to the DAC
//   VGA_HS/VS    1   active-low syncs
//   VGA_BLANK_N  1   low outside the visible area
// ---------------------------------------------------------------------------
interface vga_timing_controller_if;
    logic [7:0]  RGB_in;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [7:0]  frameCount;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;

    modport master (
        input  RGB_in,
        output pixelX, pixelY, startOfFrame, frameCount,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
    );

    modport slave (
        output RGB_in,
        input  pixelX, pixelY, startOfFrame, frameCount,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
    );
endinterface

// File: rtl/vga_timing_controller.sv
// ---------------------------------------------------------------------------
// vga_timing_controller
// Free-running VGA raster counter with sync/blank generation and a color
// output stage. The drawing logic sees pixelX/pixelY and returns RGB_in
// DRAW_LATENCY cycles later; sync, blank and color are delayed so that all
// DAC-side outputs for count (x,y) appear DRAW_LATENCY+1 cycles after the
// counters present (x,y). No stall or backpressure.
// Ports:
//   clk     pixel clock, one pixel per cycle
//   resetN  asynchronous active-low reset
//   vga     vga_timing_controller_if.master (see interface file)
// ---------------------------------------------------------------------------
module vga_timing_controller #(
    parameter int unsigned DRAW_LATENCY = 1,
    parameter int unsigned H_VIS  = 640,
    parameter int unsigned H_FP   = 16,
    parameter int unsigned H_SYNC = 96,
    parameter int unsigned H_BP   = 48,
    parameter int unsigned V_VIS  = 480,
    parameter int unsigned V_FP   = 10,
    parameter int unsigned V_SYNC = 2,
    parameter int unsigned V_BP   = 33
) (
    input  logic clk,
    input  logic resetN,
    vga_timing_controller_if.master vga
);

    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [7:0]  frame_q, frame_d;
    logic        x_wrap, y_wrap;
    logic        visible_raw, hs_raw, vs_raw;
    logic        visible_dly, hs_dly, vs_dly;
    logic        hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic [2:0]  red, green;
    logic [1:0]  blue;

    // Raster counters and raw (undelayed) timing flags
    always_comb begin
        x_wrap  = (x_q == 11'(H_TOTAL - 1));
        y_wrap  = (y_q == 11'(V_TOTAL - 1));
        x_d     = x_wrap ? 11'd0 : x_q + 11'd1;
        y_d     = y_q;
        frame_d = frame_q;
        if (x_wrap) begin
            y_d = y_wrap ? 11'd0 : y_q + 11'd1;
            if (y_wrap) begin
                frame_d = frame_q + 8'd1;
            end
        end
        visible_raw = (x_q < 11'(H_VIS)) && (y_q < 11'(V_VIS));
        hs_raw = !((x_q >= 11'(H_VIS + H_FP)) && (x_q < 11'(H_VIS + H_FP + H_SYNC)));
        vs_raw = !((y_q >= 11'(V_VIS + V_FP)) && (y_q < 11'(V_VIS + V_FP + V_SYNC)));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
        end
    end

    // Delay line matching the drawing latency; the last stage lines up with
    // the RGB_in value the drawing logic returns for that same count.
    generate
        if (DRAW_LATENCY == 0) begin : g_no_delay
            assign visible_dly = visible_raw;
            assign hs_dly      = hs_raw;
            assign vs_dly      = vs_raw;
        end else begin : g_delay
            logic [DRAW_LATENCY-1:0] vis_pipe_q, vis_pipe_d;
            logic [DRAW_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
            logic [DRAW_LATENCY-1:0] vs_pipe_q, vs_pipe_d;

            always_comb begin
                vis_pipe_d    = vis_pipe_q;
                hs_pipe_d     = hs_pipe_q;
                vs_pipe_d     = vs_pipe_q;
                vis_pipe_d[0] = visible_raw;
                hs_pipe_d[0]  = hs_raw;
                vs_pipe_d[0]  = vs_raw;
                for (int i = 1; i < int'(DRAW_LATENCY); i++) begin
                    vis_pipe_d[i] = vis_pipe_q[i-1];
                    hs_pipe_d[i]  = hs_pipe_q[i-1];
                    vs_pipe_d[i]  = vs_pipe_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    vis_pipe_q <= '0;
                    hs_pipe_q  <= '1;
                    vs_pipe_q  <= '1;
                end else begin
                    vis_pipe_q <= vis_pipe_d;
                    hs_pipe_q  <= hs_pipe_d;
                    vs_pipe_q  <= vs_pipe_d;
                end
            end

            assign visible_dly = vis_pipe_q[DRAW_LATENCY-1];
            assign hs_dly      = hs_pipe_q[DRAW_LATENCY-1];
            assign vs_dly      = vs_pipe_q[DRAW_LATENCY-1];
        end
    endgenerate

    // Output register: color expanded by bit replication, forced to black
    // outside the visible area.
    always_comb begin
        blue    = vga.RGB_in[7:6];
        red     = vga.RGB_in[5:3];
        green   = vga.RGB_in[2:0];
        hs_d    = hs_dly;
        vs_d    = vs_dly;
        blank_d = visible_dly;
        r_d     = '0;
        g_d     = '0;
        b_d     = '0;
        if (visible_dly) begin
            r_d = {red, red, red[2:1]};
            g_d = {green, green, green[2:1]};
            b_d = {blue, blue, blue, blue};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign vga.pixelX       = x_q;
    assign vga.pixelY       = y_q;
    assign vga.startOfFrame = (x_q == 11'd0) && (y_q == 11'd0);
    assign vga.frameCount   = frame_q;
    assign vga.VGA_HS       = hs_q;
    assign vga.VGA_VS       = vs_q;
    assign vga.VGA_BLANK_N  = blank_q;
    assign vga.VGA_R        = r_q;
    assign vga.VGA_G        = g_q;
    assign vga.VGA_B        = b_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_controller
// Two instances share clock and reset: dut_def uses the default 640x480
// timing (line-level checks), dut_sm uses a 25x10 raster so frame timing and
// the 255->0 frameCount wrap fit in a short run. Cycle index cyc counts
// from the first cycle after reset release (cyc 0 presents (0,0)).
// ---------------------------------------------------------------------------
module tb_vga_timing_controller;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    vga_timing_controller_if vif_def ();
    vga_timing_controller_if vif_sm ();

    vga_timing_controller dut_def (
        .clk    (clk),
        .resetN (resetN),
        .vga    (vif_def)
    );

    // Small raster: H 16+2+4+3 = 25, V 6+1+2+1 = 10, frame = 250 cycles
    vga_timing_controller #(
        .DRAW_LATENCY (1),
        .H_VIS (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_VIS (6),  .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_sm (
        .clk    (clk),
        .resetN (resetN),
        .vga    (vif_sm)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  rgb;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
        logic        hs;
        logic        vs;
        logic        blank;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } vec_t;

    vec_t tbl[13];

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    int hs_low_def = 0;
    int hs_low_sm = 0;
    int vs_low_sm = 0;
    int sof_sm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic sample_counts();
        if (vif_def.VGA_HS == 1'b0) hs_low_def++;
        if (vif_sm.VGA_HS == 1'b0)  hs_low_sm++;
        if (vif_sm.VGA_VS == 1'b0)  vs_low_sm++;
        if (vif_sm.startOfFrame)    sof_sm++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        sample_counts();
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        resetN = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        resetN = 1'b1;
        #1;
        cyc = 0;
        hs_low_def = 0;
        hs_low_sm = 0;
        vs_low_sm = 0;
        sof_sm = 0;
        sample_counts();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " def pixelX"}, vif_def.pixelX, 0);
        chk({tag, " def pixelY"}, vif_def.pixelY, 0);
        chk({tag, " def frameCount"}, vif_def.frameCount, 0);
        chk({tag, " def HS"}, vif_def.VGA_HS, 1);
        chk({tag, " def VS"}, vif_def.VGA_VS, 1);
        chk({tag, " def BLANK_N"}, vif_def.VGA_BLANK_N, 0);
        chk({tag, " def RGB"}, {vif_def.VGA_R, vif_def.VGA_G, vif_def.VGA_B}, 0);
        chk({tag, " sm pixelX"}, vif_sm.pixelX, 0);
        chk({tag, " sm pixelY"}, vif_sm.pixelY, 0);
        chk({tag, " sm frameCount"}, vif_sm.frameCount, 0);
        chk({tag, " sm HS"}, vif_sm.VGA_HS, 1);
        chk({tag, " sm VS"}, vif_sm.VGA_VS, 1);
        chk({tag, " sm BLANK_N"}, vif_sm.VGA_BLANK_N, 0);
        chk({tag, " sm RGB"}, {vif_sm.VGA_R, vif_sm.VGA_G, vif_sm.VGA_B}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Line vectors on the default raster, RGB_in held at 10_101_011:
        // R = {101,101,10} = B6, G = {011,011,01} = 6D, B = {10,10,10,10} = AA.
        //            cyc  rgb    x        y      sof   hs    vs    blank  r      g      b
        tbl[0]  = '{0,   8'hAB, 11'd0,   11'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1,   8'hAB, 11'd1,   11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{2,   8'hAB, 11'd2,   11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB6, 8'h6D, 8'hAA};
        tbl[3]  = '{641, 8'hAB, 11'd641, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB6, 8'h6D, 8'hAA};
        tbl[4]  = '{642, 8'hAB, 11'd642, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[5]  = '{657, 8'hAB, 11'd657, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[6]  = '{658, 8'hAB, 11'd658, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[7]  = '{753, 8'hAB, 11'd753, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[8]  = '{754, 8'hAB, 11'd754, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[9]  = '{799, 8'hAB, 11'd799, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[10] = '{800, 8'hAB, 11'd0,   11'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[11] = '{801, 8'hAB, 11'd1,   11'd1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[12] = '{802, 8'hAB, 11'd2,   11'd1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB6, 8'h6D, 8'hAA};

        vif_def.RGB_in = 8'hAB;
        vif_sm.RGB_in  = 8'hFF;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("init");

        // Line timing and constant-color path on the default raster
        release_reset();
        for (int i = 0; i < 13; i++) begin
            while (cyc < tbl[i].cyc) begin
                step();
                vif_def.RGB_in = tbl[i].rgb;
            end
            chk($sformatf("line[%0d] pixelX", i), vif_def.pixelX, tbl[i].x);
            chk($sformatf("line[%0d] pixelY", i), vif_def.pixelY, tbl[i].y);
            chk($sformatf("line[%0d] startOfFrame", i), vif_def.startOfFrame, tbl[i].sof);
            chk($sformatf("line[%0d] HS", i), vif_def.VGA_HS, tbl[i].hs);
            chk($sformatf("line[%0d] VS", i), vif_def.VGA_VS, tbl[i].vs);
            chk($sformatf("line[%0d] BLANK_N", i), vif_def.VGA_BLANK_N, tbl[i].blank);
            chk($sformatf("line[%0d] R", i), vif_def.VGA_R, tbl[i].r);
            chk($sformatf("line[%0d] G", i), vif_def.VGA_G, tbl[i].g);
            chk($sformatf("line[%0d] B", i), vif_def.VGA_B, tbl[i].b);
        end
        chk("line HS low cycles", hs_low_def, 96);

        // Alignment: RGB_in follows pixelX[7:0] delayed by one cycle
        apply_reset(2);
        vif_def.RGB_in = 8'h00;
        release_reset();
        while (cyc < 642) begin
            step();
            vif_def.RGB_in = 8'(cyc - 1);
            if (cyc == 7) begin
                // 8'h05 -> b=00 r=000 g=101
                chk("align x5 R", vif_def.VGA_R, 8'h00);
                chk("align x5 G", vif_def.VGA_G, 8'hB6);
                chk("align x5 B", vif_def.VGA_B, 8'h00);
            end
            if (cyc == 202) begin
                // 8'hC8 -> b=11 r=001 g=000
                chk("align x200 R", vif_def.VGA_R, 8'h24);
                chk("align x200 G", vif_def.VGA_G, 8'h00);
                chk("align x200 B", vif_def.VGA_B, 8'hFF);
            end
            if (cyc == 641) chk("align x639 BLANK_N", vif_def.VGA_BLANK_N, 1);
        end
        chk("align x640 BLANK_N", vif_def.VGA_BLANK_N, 0);
        chk("align x640 RGB", {vif_def.VGA_R, vif_def.VGA_G, vif_def.VGA_B}, 0);

        // Frame timing and frameCount wrap on the small raster
        apply_reset(2);
        release_reset();
        while (cyc < 64000) begin
            step();
            if (cyc == 2) begin
                chk("sm first BLANK_N", vif_sm.VGA_BLANK_N, 1);
                chk("sm first RGB", {vif_sm.VGA_R, vif_sm.VGA_G, vif_sm.VGA_B}, 24'hFFFFFF);
            end
            if (cyc == 18) begin
                chk("sm x16 BLANK_N", vif_sm.VGA_BLANK_N, 0);
                chk("sm x16 RGB", {vif_sm.VGA_R, vif_sm.VGA_G, vif_sm.VGA_B}, 0);
            end
            if (cyc == 24) chk("sm HS low cycles", hs_low_sm, 4);
            if (cyc == 249) begin
                chk("sm VS low cycles", vs_low_sm, 50);
                chk("sm sof pulses", sof_sm, 1);
                chk("sm end pixelX", vif_sm.pixelX, 24);
                chk("sm end pixelY", vif_sm.pixelY, 9);
                chk("sm end frameCount", vif_sm.frameCount, 0);
            end
            if (cyc == 250) begin
                chk("sm wrap pixelX", vif_sm.pixelX, 0);
                chk("sm wrap pixelY", vif_sm.pixelY, 0);
                chk("sm wrap sof", vif_sm.startOfFrame, 1);
                chk("sm frameCount 1", vif_sm.frameCount, 1);
            end
            if (cyc == 63750) chk("sm frameCount 255", vif_sm.frameCount, 255);
            if (cyc == 63999) chk("sm frameCount pre-wrap", vif_sm.frameCount, 255);
        end
        chk("sm frameCount wrap", vif_sm.frameCount, 0);
        chk("sm frameCount wrap sof", vif_sm.startOfFrame, 1);

        // Reset mid-frame: small raster at (10,4) of frame 257
        while (cyc < 64360) step();
        chk("mid pixelX", vif_sm.pixelX, 10);
        chk("mid pixelY", vif_sm.pixelY, 4);
        chk("mid frameCount", vif_sm.frameCount, 1);
        chk("mid BLANK_N", vif_sm.VGA_BLANK_N, 1);
        resetN = 1'b0;
        #1;
        check_reset_values("midrst0");
        for (int k = 1; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_reset_values($sformatf("midrst%0d", k));
        end
        @(posedge clk);
        #1;
        release_reset();
        chk("rel pixelX", vif_sm.pixelX, 0);
        chk("rel pixelY", vif_sm.pixelY, 0);
        chk("rel sof", vif_sm.startOfFrame, 1);
        chk("rel BLANK_N c0", vif_sm.VGA_BLANK_N, 0);
        step();
        chk("rel BLANK_N c1", vif_sm.VGA_BLANK_N, 0);
        chk("rel def BLANK_N c1", vif_def.VGA_BLANK_N, 0);
        step();
        chk("rel BLANK_N c2", vif_sm.VGA_BLANK_N, 1);
        chk("rel def BLANK_N c2", vif_def.VGA_BLANK_N, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
